stream_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one valid/ready pipeline (shift register, custom logic, shift register) among N_REQ upstream requesters.
- Sits in front of the first shift-register stage.
- Merges requester streams into one registered downstream stream, tagged with the source index.
- Grants are held for bursts of up to MAX_BURST beats to limit re-arbitration bubbles.

---
 rtl/stream_arb_pkg.sv | 42 ++++
 rtl/stream_rr_arbiter_select.sv | 31 +++
 rtl/stream_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and helpers for the streaming round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE while choosing, GRANT while serving)
//   rr_pick     : index of the first set request bit at or after a pointer,
//                 wrapping around n requesters
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Widest request vector rr_pick can search; callers zero-extend into it.
    localparam int unsigned ARB_MAX_REQ = 32;

    function automatic int unsigned rr_pick(
        input logic [ARB_MAX_REQ-1:0] valid,
        input int unsigned            ptr,
        input int unsigned            n
    );
        int unsigned idx;
        int unsigned pick;
        pick = 0;
        // Scan from the farthest candidate back to ptr so that the nearest
        // set bit (in round-robin order) is the last one written.
        for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
            if (k < int'(n)) begin
                idx = ptr + 32'(k);
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_select.sv
// -----------------------------------------------------------------------------
// rr_pointer_select
// Combinational round-robin priority picker. Returns the first requester at
// or after ptr_i (wrapping) whose request bit is set.
//   req_i  : request vector, one bit per requester
//   ptr_i  : highest-priority index for this evaluation
//   pick_o : selected index (only meaningful when any_o is high)
//   any_o  : at least one request is present
// -----------------------------------------------------------------------------
module rr_pointer_select
    import stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SRC_W-1:0] ptr_i,
    output logic [SRC_W-1:0] pick_o,
    output logic             any_o
);

    logic [ARB_MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req_i;
        any_o                = |req_i;
        pick_o               = SRC_W'(rr_pick(req_ext, 32'(ptr_i), 32'(N_REQ)));
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Round-robin arbiter merging N_REQ valid/ready requester streams into one
// registered downstream stream tagged with the source index. A grant is held
// for up to MAX_BURST beats; every re-arbitration spends one IDLE cycle.
//   clk        : clock
//   rst        : asynchronous reset, active low
//   up_data    : requester i data at [i*D_WIDTH +: D_WIDTH]
//   up_valid   : per-requester valid
//   up_ready   : per-requester ready, at most one bit high
//   down_data  : registered output data
//   down_src   : requester index that produced down_data
//   down_valid : registered output valid
//   down_ready : downstream ready
//   busy       : high while a grant is held
// -----------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int D_WIDTH   = 6,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*D_WIDTH-1:0]   up_data,
    input  logic [N_REQ-1:0]           up_valid,
    output logic [N_REQ-1:0]           up_ready,
    output logic [D_WIDTH-1:0]         down_data,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] down_src,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic                       busy
);

    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(N_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dvalid_q, dvalid_d;
    logic [D_WIDTH-1:0] ddata_q, ddata_d;
    logic [SRC_W-1:0]   dsrc_q, dsrc_d;

    logic [D_WIDTH-1:0] up_data_a [N_REQ];
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               in_grant;
    logic               grant_valid;
    logic               can_load;
    logic               xfer;
    logic               release_grant;
    logic [SRC_W-1:0]   ptr_next;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign up_data_a[i] = up_data[i*D_WIDTH +: D_WIDTH];
    end

    rr_pointer_select #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_select (
        .req_i  (up_valid),
        .ptr_i  (ptr_q),
        .pick_o (pick_idx),
        .any_o  (pick_any)
    );

    assign in_grant    = (state_q == GRANT);
    assign grant_valid = up_valid[grant_q];
    // Output register can take a new beat when empty or being drained now.
    assign can_load    = !dvalid_q || down_ready;
    assign xfer        = in_grant && grant_valid && can_load;
    // A dropped valid releases the grant even while the output is stalled.
    assign release_grant = (xfer && (cnt_q == LAST_BEAT)) || !grant_valid;
    assign ptr_next    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    // Ready depends only on registered state and down_ready, never on up_valid.
    always_comb begin
        up_ready = '0;
        if (in_grant && can_load) begin
            up_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        dsrc_d   = dsrc_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_grant) begin
                    ptr_d   = ptr_next;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer) begin
            ddata_d  = up_data_a[grant_q];
            dsrc_d   = grant_q;
            dvalid_d = 1'b1;
        end else if (down_ready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            dsrc_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            dsrc_q   <= dsrc_d;
        end
    end

    assign down_valid = dvalid_q;
    assign down_data  = ddata_q;
    assign down_src   = dsrc_q;
    assign busy       = in_grant;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

    localparam int D_WIDTH   = 6;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int SRC_W     = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_REQ*D_WIDTH-1:0] up_data;
    logic [N_REQ-1:0]         up_valid;
    logic [N_REQ-1:0]         up_ready;
    logic [D_WIDTH-1:0]       down_data;
    logic [SRC_W-1:0]         down_src;
    logic                     down_valid;
    logic                     down_ready;
    logic                     busy;

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .D_WIDTH   (D_WIDTH),
        .N_REQ     (N_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_src   (down_src),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .busy       (busy)
    );

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [D_WIDTH-1:0] data;
    } beat_t;

    beat_t              exp_q[$];
    logic [D_WIDTH-1:0] base [N_REQ] = '{6'h00, 6'h20, 6'h15, 6'h30};
    int                 rem     [N_REQ];
    int                 seq     [N_REQ];
    int                 exp_seq [N_REQ];
    int                 acc     [N_REQ];
    logic               dr;
    int                 cyc;
    int                 first_dn;
    int                 last_dn;
    int                 n_checks = 0;
    int                 n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rem_total();
        int s = 0;
        for (int i = 0; i < N_REQ; i++) s += rem[i];
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            up_valid[i] = (rem[i] > 0);
            up_data[i*D_WIDTH +: D_WIDTH] = base[i] + D_WIDTH'(seq[i]);
        end
        down_ready = dr;
    endtask

    task automatic push_beats(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.src  = SRC_W'(src);
            b.data = base[src] + D_WIDTH'(exp_seq[src]);
            exp_seq[src]++;
            exp_q.push_back(b);
        end
    endtask

    // One clock: sample/score at the falling edge, then update requesters
    // and drive new inputs just after the rising edge.
    task automatic run_cycle();
        logic [N_REQ-1:0] hs;
        beat_t            want;
        @(negedge clk);
        cyc++;
        check_eq("up_ready_onehot", 32'($countones(up_ready) <= 1), 32'd1);
        hs = up_valid & up_ready;
        if (down_valid && down_ready) begin
            if (first_dn < 0) first_dn = cyc;
            last_dn = cyc;
            check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check_eq("beat_src", 32'(down_src), 32'(want.src));
                check_eq("beat_data", 32'(down_data), 32'(want.data));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i]) begin
                seq[i]++;
                rem[i]--;
                acc[i]++;
            end
        end
        drive();
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rem_total() > 0) && n < budget) begin
            run_cycle();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(n < budget), 32'd1);
        exp_q.delete();
        repeat (3) run_cycle();
    endtask

    task automatic start_scn();
        for (int i = 0; i < N_REQ; i++) acc[i] = 0;
        first_dn = -1;
        last_dn  = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [D_WIDTH-1:0] held;
        int                 n;

        rst = 1'b0;
        dr  = 1'b1;
        cyc = 0;
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0; seq[i] = 0; exp_seq[i] = 0; acc[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_down_valid", 32'(down_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_up_ready", 32'(up_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_down_valid", 32'(down_valid), 32'd0);
        check_eq("post_rst_down_data", 32'(down_data), 32'd0);
        check_eq("post_rst_down_src", 32'(down_src), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        // Single requester 2, burst of four starting at 0x15.
        start_scn();
        rem[2] = 4;
        push_beats(2, 4);
        drive();
        #1;
        check_eq("s1_idle_up_ready", 32'(up_ready), 32'd0);
        check_eq("s1_idle_busy", 32'(busy), 32'd0);
        run_cycle();
        check_eq("s1_grant_up_ready", 32'(up_ready), 32'b0100);
        check_eq("s1_grant_busy", 32'(busy), 32'd1);
        run_cycle();
        check_eq("s1_down_valid", 32'(down_valid), 32'd1);
        check_eq("s1_down_data", 32'(down_data), 32'h15);
        check_eq("s1_down_src", 32'(down_src), 32'd2);
        repeat (3) run_cycle();
        check_eq("s1_release_busy", 32'(busy), 32'd0);
        check_eq("s1_release_up_ready", 32'(up_ready), 32'd0);
        drain("s1", 50);

        // Pointer now 3: with only 0 and 3 requesting, 3 goes first.
        start_scn();
        rem[0] = 4;
        rem[3] = 4;
        push_beats(3, 4);
        push_beats(0, 4);
        drive();
        run_cycle();
        check_eq("wrap_first_grant", 32'(up_ready), 32'b1000);
        drain("wrap", 100);

        // Requester 1 drops after two beats; next grant searches from 2.
        start_scn();
        rem[1] = 2;
        rem[3] = 4;
        rem[0] = 4;
        push_beats(1, 2);
        push_beats(3, 4);
        push_beats(0, 4);
        drive();
        drain("drop", 100);

        // Five-cycle downstream stall after the second beat of a burst.
        start_scn();
        rem[1] = 6;
        rem[2] = 4;
        push_beats(1, 4);
        push_beats(2, 4);
        push_beats(1, 2);
        drive();
        n = 0;
        while (acc[1] < 2 && n < 50) begin
            run_cycle();
            n++;
        end
        check_eq("stall_reached", 32'(acc[1]), 32'd2);
        held = base[1] + D_WIDTH'(seq[1] - 1);
        dr = 1'b0;
        drive();
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_up_ready", 32'(up_ready), 32'd0);
            check_eq("stall_down_valid", 32'(down_valid), 32'd1);
            check_eq("stall_down_data", 32'(down_data), 32'(held));
            run_cycle();
        end
        dr = 1'b1;
        drive();
        drain("stall", 100);

        // Asynchronous reset in the middle of a burst.
        start_scn();
        rem[2] = 4;
        rem[3] = 4;
        push_beats(2, 2);
        drive();
        n = 0;
        while (acc[2] < 2 && n < 50) begin
            run_cycle();
            n++;
        end
        check_eq("areset_reached", 32'(acc[2]), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("areset_down_valid", 32'(down_valid), 32'd0);
        check_eq("areset_busy", 32'(busy), 32'd0);
        check_eq("areset_up_ready", 32'(up_ready), 32'd0);
        exp_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            rem[i]     = 0;
            exp_seq[i] = seq[i];
        end
        drive();
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting: arbitration restarts from index 0.
        start_scn();
        rem[0] = 8;
        rem[1] = 4;
        rem[2] = 4;
        rem[3] = 4;
        push_beats(0, 4);
        push_beats(1, 4);
        push_beats(2, 4);
        push_beats(3, 4);
        push_beats(0, 4);
        drive();
        drain("all4", 200);
        check_eq("all4_span_one_bubble", 32'(last_dn - first_dn + 1), 32'd24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
